// File: rtl/flappy_game_ctrl.sv
// Flappy-fish game sequencer: physics tick generation, fish motion
// integration, pipelined pipe-table collision/score scan and the
// one-hot game state consumed by the renderer, LEDs and SSD logic.
module flappy_game_ctrl #(
    parameter int TICK_DIV   = 2097152,
    parameter int PIPE_COUNT = 5,
    parameter int START_Y    = 150,
    parameter int FLAP_DY    = 2,
    parameter int VEL_MAX    = 15,
    parameter int Y_MAX      = 479,
    parameter int WIN_X      = 620
) (
    input  logic       board_clk,
    input  logic       reset,
    input  logic       start,
    input  logic       flap,
    output logic [2:0] pipe_idx,
    input  logic [9:0] pipe_x_lo,
    input  logic [9:0] pipe_x_hi,
    input  logic [9:0] gap_top,
    input  logic [9:0] gap_bot,
    output logic [9:0] pos_x,
    output logic [9:0] pos_y,
    output logic [3:0] state,
    output logic [3:0] score,
    output logic       tick,
    output logic       scan_busy
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [2:0] SCAN_LAST = 3'(PIPE_COUNT);
    localparam logic [9:0] START_Y_V = 10'(START_Y);
    localparam logic [9:0] FLAP_DY_V = 10'(FLAP_DY);
    localparam logic [9:0] VEL_MAX_V = 10'(VEL_MAX);
    localparam logic [9:0] Y_MAX_V   = 10'(Y_MAX);
    localparam logic [9:0] WIN_X_V   = 10'(WIN_X);

    typedef enum logic [3:0] {
        S_INIT = 4'b1000,
        S_GAME = 4'b0100,
        S_DIE  = 4'b0010,
        S_WIN  = 4'b0001
    } state_t;

    state_t           state_reg, state_next;
    logic             start_meta_reg, start_s_reg;
    logic             flap_meta_reg, flap_s_reg;
    logic [CNT_W-1:0] tick_cnt_reg;
    logic [9:0]       pos_x_reg, pos_x_next;
    logic [9:0]       pos_y_reg, pos_y_next;
    logic [9:0]       vel_reg, vel_next;
    logic [3:0]       score_reg, score_next;
    logic             scan_busy_reg, scan_busy_next;
    logic [2:0]       scan_cnt_reg, scan_cnt_next;
    logic             hit_reg, hit_next;

    logic             tick_now;
    logic [10:0]      y_fall;
    logic [10:0]      vel_inc;
    logic             eval_now;
    logic             scan_last;
    logic             entry_hit;
    logic             ground_hit;
    logic             pass_hit;

    assign tick_now   = (tick_cnt_reg == TICK_LAST);
    assign y_fall     = {1'b0, pos_y_reg} + {1'b0, vel_reg};
    assign vel_inc    = {1'b0, vel_reg} + 11'd1;
    // scan_cnt k (k>=1) means table data for entry k-1 is on the inputs now
    assign eval_now   = scan_busy_reg && (scan_cnt_reg != 3'd0);
    assign scan_last  = scan_busy_reg && (scan_cnt_reg == SCAN_LAST);
    assign entry_hit  = (pipe_x_lo < pos_x_reg) && (pos_x_reg < pipe_x_hi) &&
                        ((pos_y_reg < gap_top) || (pos_y_reg > gap_bot));
    assign ground_hit = (scan_cnt_reg == 3'd1) && (pos_y_reg == Y_MAX_V);
    assign pass_hit   = (pos_x_reg == pipe_x_hi);

    assign tick      = tick_now;
    assign scan_busy = scan_busy_reg;
    assign pipe_idx  = (scan_busy_reg && (scan_cnt_reg < SCAN_LAST)) ? scan_cnt_reg : 3'd0;
    assign pos_x     = pos_x_reg;
    assign pos_y     = pos_y_reg;
    assign score     = score_reg;
    assign state     = state_reg;

    // Two-flop synchronizers for the raw push buttons
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            start_meta_reg <= 1'b0;
            start_s_reg    <= 1'b0;
            flap_meta_reg  <= 1'b0;
            flap_s_reg     <= 1'b0;
        end else begin
            start_meta_reg <= start;
            start_s_reg    <= start_meta_reg;
            flap_meta_reg  <= flap;
            flap_s_reg     <= flap_meta_reg;
        end
    end

    // Free-running physics tick divider, wraps after the tick cycle
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            tick_cnt_reg <= '0;
        end else if (tick_now) begin
            tick_cnt_reg <= '0;
        end else begin
            tick_cnt_reg <= tick_cnt_reg + CNT_W'(1);
        end
    end

    // Game state register
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_INIT;
        end else begin
            state_reg <= state_next;
        end
    end

    // Fish kinematics, score and scan bookkeeping registers
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            pos_x_reg     <= '0;
            pos_y_reg     <= START_Y_V;
            vel_reg       <= '0;
            score_reg     <= '0;
            scan_busy_reg <= 1'b0;
            scan_cnt_reg  <= '0;
            hit_reg       <= 1'b0;
        end else begin
            pos_x_reg     <= pos_x_next;
            pos_y_reg     <= pos_y_next;
            vel_reg       <= vel_next;
            score_reg     <= score_next;
            scan_busy_reg <= scan_busy_next;
            scan_cnt_reg  <= scan_cnt_next;
            hit_reg       <= hit_next;
        end
    end

    // Next-state: tick-driven motion update, then the pipe scan and its verdict
    always_comb begin
        state_next     = state_reg;
        pos_x_next     = pos_x_reg;
        pos_y_next     = pos_y_reg;
        vel_next       = vel_reg;
        score_next     = score_reg;
        scan_busy_next = scan_busy_reg;
        scan_cnt_next  = scan_cnt_reg;
        hit_next       = hit_reg;
        case (state_reg)
            S_INIT: begin
                pos_x_next = '0;
                pos_y_next = START_Y_V;
                vel_next   = '0;
                score_next = '0;
                if (start_s_reg) begin
                    state_next = S_GAME;
                end
            end
            S_GAME: begin
                if (tick_now && !scan_busy_reg) begin
                    if (flap_s_reg) begin
                        vel_next   = '0;
                        pos_y_next = (pos_y_reg < FLAP_DY_V) ? 10'd0 : (pos_y_reg - FLAP_DY_V);
                    end else begin
                        pos_y_next = (y_fall > {1'b0, Y_MAX_V}) ? Y_MAX_V : y_fall[9:0];
                        vel_next   = (vel_inc > {1'b0, VEL_MAX_V}) ? VEL_MAX_V : vel_inc[9:0];
                    end
                    pos_x_next     = (pos_x_reg == 10'd1023) ? pos_x_reg : (pos_x_reg + 10'd1);
                    scan_busy_next = 1'b1;
                    scan_cnt_next  = '0;
                    hit_next       = 1'b0;
                end else if (scan_busy_reg) begin
                    scan_cnt_next = scan_cnt_reg + 3'd1;
                    if (eval_now) begin
                        if (entry_hit || ground_hit) begin
                            hit_next = 1'b1;
                        end
                        if (pass_hit && (score_reg != 4'd15)) begin
                            score_next = score_reg + 4'd1;
                        end
                    end
                    if (scan_last) begin
                        scan_busy_next = 1'b0;
                        scan_cnt_next  = '0;
                        // a collision outranks reaching the win column
                        if (hit_reg || entry_hit || ground_hit) begin
                            state_next = S_DIE;
                        end else if (pos_x_reg >= WIN_X_V) begin
                            state_next = S_WIN;
                        end
                    end
                end
            end
            default: begin
                // DIE and WIN are terminal: everything stays frozen
            end
        endcase
    end

    tick_outside_scan: assert property (@(posedge board_clk) disable iff (reset)
                                        !(tick_now && scan_busy_reg));

endmodule
